// File: rtl/lru_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lru_priority_arbiter
// Purpose  : N-port least-recently-granted arbiter. A full rank list
//            (permutation of port indices) lives in registers. Each cycle the
//            highest-ranked requester receives a registered one-hot grant and
//            is demoted to the lowest rank.
// Options  : ARB_LOCK_EN - adds the lock input so the current grant holder
//            can keep the grant (and freeze the order) for a burst.
// Revision : 1.0 - initial release
// ============================================================================
module lru_priority_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         halt,
  input  logic [NUM_PORTS-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic                         lock,
`endif
  output logic [NUM_PORTS-1:0]         grant,
  output logic                         grant_valid,
  output logic [IDX_W-1:0]             grant_idx,
  output logic [NUM_PORTS*IDX_W-1:0]   priority_order
);

  localparam logic [NUM_PORTS-1:0] ONE_HOT_LSB = NUM_PORTS'(1);

  // Rank list: slot 0 is the highest priority.
  logic [IDX_W-1:0] r_order      [NUM_PORTS];
  logic [IDX_W-1:0] w_next_order [NUM_PORTS];
  logic             w_found;
  logic [IDX_W-1:0] w_win_port;
  logic [IDX_W-1:0] w_win_slot;
  logic             w_hold;

  // Winner is the requester sitting in the lowest-numbered rank slot; the
  // descending scan lets the lowest matching slot overwrite the others.
  always_comb begin
    w_found    = 1'b0;
    w_win_port = '0;
    w_win_slot = '0;
    for (int s = NUM_PORTS - 1; s >= 0; s--) begin
      if (req[r_order[s]]) begin
        w_found    = 1'b1;
        w_win_port = r_order[s];
        w_win_slot = IDX_W'(s);
      end
    end
  end

  // Demote the winner: slots above it keep their entries, slots below it
  // shift up one place, and the winner lands in the last slot.
  always_comb begin
    for (int s = 0; s < NUM_PORTS - 1; s++) begin
      if (w_found && (IDX_W'(s) >= w_win_slot)) begin
        w_next_order[s] = r_order[s + 1];
      end else begin
        w_next_order[s] = r_order[s];
      end
    end
    w_next_order[NUM_PORTS-1] = w_found ? w_win_port : r_order[NUM_PORTS-1];
  end

`ifdef ARB_LOCK_EN
  // A locked holder that still requests keeps its grant and freezes the order.
  assign w_hold = lock && grant_valid && req[grant_idx];
`else
  assign w_hold = 1'b0;
`endif

  // Rank list and registered grant outputs; reset overrides halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_PORTS; s++) begin
        r_order[s] <= IDX_W'(s);
      end
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else if (!halt && !w_hold) begin
      for (int s = 0; s < NUM_PORTS; s++) begin
        r_order[s] <= w_next_order[s];
      end
      if (w_found) begin
        grant       <= ONE_HOT_LSB << w_win_port;
        grant_valid <= 1'b1;
        grant_idx   <= w_win_port;
      end else begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_idx   <= '0;
      end
    end
  end

  // Flatten the rank list onto the output bus, slot r at [r*IDX_W +: IDX_W].
  for (genvar r = 0; r < NUM_PORTS; r++) begin : g_order_flat
    assign priority_order[r*IDX_W +: IDX_W] = r_order[r];
  end

endmodule
`default_nettype wire

// File: tb/tb_lru_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lru_priority_arbiter
// Purpose  : Self-checking bench for lru_priority_arbiter with a 4-port and a
//            3-port instance, directed scenarios plus randomized traffic
//            against a rank-list reference model. Lock scenario is built
//            when ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lru_priority_arbiter;

`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       halt  = 1'b0;
  logic       lock  = 1'b0;
  logic [3:0] req4  = '0;
  logic [2:0] req3  = '0;

  logic [3:0] grant4;
  logic       gv4;
  logic [1:0] gi4;
  logic [7:0] po4;
  logic [2:0] grant3;
  logic       gv3;
  logic [1:0] gi3;
  logic [5:0] po3;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Reference model: rank list per instance (0 = 4-port, 1 = 3-port).
  int m_ord   [2][16];
  int m_idx   [2];
  bit m_valid [2];
  int m_n     [2] = '{4, 3};

  always #5 clk = ~clk;

  lru_priority_arbiter #(.NUM_PORTS(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .req            (req4),
`ifdef ARB_LOCK_EN
    .lock           (lock),
`endif
    .grant          (grant4),
    .grant_valid    (gv4),
    .grant_idx      (gi4),
    .priority_order (po4)
  );

  lru_priority_arbiter #(.NUM_PORTS(3)) dut3 (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .req            (req3),
`ifdef ARB_LOCK_EN
    .lock           (lock),
`endif
    .grant          (grant3),
    .grant_valid    (gv3),
    .grant_idx      (gi3),
    .priority_order (po3)
  );

  // Rank-list model: first requester in rank order wins and moves to the back.
  task automatic model_step(input int k, input logic [3:0] rq);
    int  w;
    int  r;
    bit  f;
    if (reset) begin
      for (int i = 0; i < m_n[k]; i++) m_ord[k][i] = i;
      m_valid[k] = 1'b0;
      m_idx[k]   = 0;
    end else if (!halt) begin
      if (!(LOCK_EN && lock && m_valid[k] && rq[m_idx[k]])) begin
        f = 1'b0;
        r = 0;
        for (int i = 0; i < m_n[k]; i++) begin
          if (!f && rq[m_ord[k][i]]) begin
            f = 1'b1;
            r = i;
          end
        end
        if (f) begin
          w = m_ord[k][r];
          for (int i = r; i < m_n[k] - 1; i++) m_ord[k][i] = m_ord[k][i+1];
          m_ord[k][m_n[k]-1] = w;
          m_valid[k] = 1'b1;
          m_idx[k]   = w;
        end else begin
          m_valid[k] = 1'b0;
          m_idx[k]   = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model at the
  // rising edge, return 1 time unit after it.
  task automatic tick(input logic r, input logic h, input logic [3:0] q4,
                      input logic [2:0] q3, input logic lk);
    @(negedge clk);
    reset = r;
    halt  = h;
    req4  = q4;
    req3  = q3;
    lock  = lk;
    @(posedge clk);
    model_step(0, q4);
    model_step(1, {1'b0, q3});
    if (r) started = 1'b1;
    #1;
  endtask

  // Every cycle after the first reset both rank lists must be permutations
  // and the 3-port grant index must stay below 3.
  always @(negedge clk) begin : perm_check
    logic [3:0] seen4;
    logic [3:0] seen3;
    bit ok;
    if (started) begin
      seen4 = '0;
      seen3 = '0;
      ok    = 1'b1;
      for (int r = 0; r < 4; r++) seen4[po4[r*2 +: 2]] = 1'b1;
      for (int r = 0; r < 3; r++) seen3[po3[r*2 +: 2]] = 1'b1;
      if (seen4 !== 4'b1111) ok = 1'b0;
      if (seen3 !== 4'b0111) ok = 1'b0;
      if (gi3 === 2'd3)      ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL perm_invariant t=%0t po4=%h po3=%h gi3=%0d required permutations and gi3<3",
                 $time, po4, po3, gi3);
      end
    end
  end

  task automatic test_reset_rotation();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ei [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tick(1, 0, 4'h0, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0 || gv4 !== 1'b0 || gi4 !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b valid=%b idx=%0d required 0000/0/0", grant4, gv4, gi4);
    end
    total++;
    if (po4 !== 8'hE4) begin
      bad++;
      $display("FAIL reset_order got %h required e4", po4);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 4'hF, 3'h0, 0);
      total++;
      if (grant4 !== eg[i] || gi4 !== ei[i] || gv4 !== 1'b1) begin
        bad++;
        $display("FAIL rotation[%0d] got grant=%b idx=%0d valid=%b required %b/%0d/1",
                 i, grant4, gi4, gv4, eg[i], ei[i]);
      end
      if (i == 0) begin
        total++;
        if (po4 !== 8'h39) begin
          bad++;
          $display("FAIL rotation_order got %h required 39", po4);
        end
      end
    end
  endtask

  task automatic test_single_and_pair();
    tick(1, 0, 4'h0, 3'h0, 0);
    tick(0, 0, 4'b0100, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0100 || gi4 !== 2'd2 || po4 !== 8'hB4) begin
      bad++;
      $display("FAIL single_req got grant=%b idx=%0d order=%h required 0100/2/b4", grant4, gi4, po4);
    end
    tick(0, 0, 4'b0101, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0001 || gi4 !== 2'd0 || po4 !== 8'h2D) begin
      bad++;
      $display("FAIL pair_req got grant=%b idx=%0d order=%h required 0001/0/2d", grant4, gi4, po4);
    end
    tick(0, 0, 4'b0000, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0 || gv4 !== 1'b0 || gi4 !== 2'd0 || po4 !== 8'h2D) begin
      bad++;
      $display("FAIL no_req got grant=%b valid=%b idx=%0d order=%h required 0000/0/0/2d",
               grant4, gv4, gi4, po4);
    end
  endtask

  task automatic test_halt();
    tick(1, 0, 4'h0, 3'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'hF, 3'h0, 0);
      total++;
      if (grant4 !== 4'b0 || gv4 !== 1'b0 || po4 !== 8'hE4) begin
        bad++;
        $display("FAIL halt_idle[%0d] got grant=%b valid=%b order=%h required 0000/0/e4",
                 i, grant4, gv4, po4);
      end
    end
    tick(0, 0, 4'hF, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0001 || gv4 !== 1'b1) begin
      bad++;
      $display("FAIL halt_release got grant=%b valid=%b required 0001/1", grant4, gv4);
    end
    tick(0, 1, 4'b0100, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0001 || gv4 !== 1'b1 || gi4 !== 2'd0 || po4 !== 8'h39) begin
      bad++;
      $display("FAIL halt_hold got grant=%b valid=%b idx=%0d order=%h required 0001/1/0/39",
               grant4, gv4, gi4, po4);
    end
  endtask

  task automatic test_reset_midop();
    tick(1, 0, 4'h0, 3'h0, 0);
    tick(0, 0, 4'hF, 3'h0, 0);
    tick(1, 1, 4'hF, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0 || gv4 !== 1'b0 || gi4 !== 2'd0 || po4 !== 8'hE4) begin
      bad++;
      $display("FAIL reset_midop got grant=%b valid=%b idx=%0d order=%h required 0000/0/0/e4",
               grant4, gv4, gi4, po4);
    end
    tick(0, 0, 4'hF, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0001 || gv4 !== 1'b1) begin
      bad++;
      $display("FAIL after_reset got grant=%b valid=%b required 0001/1", grant4, gv4);
    end
  endtask

  task automatic test_three_ports();
    logic [1:0] ei [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    tick(1, 0, 4'h0, 3'h0, 0);
    total++;
    if (po3 !== 6'h24 || gv3 !== 1'b0) begin
      bad++;
      $display("FAIL n3_reset got order=%h valid=%b required 24/0", po3, gv3);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 4'h0, 3'b111, 0);
      total++;
      if (gi3 !== ei[i] || grant3 !== (3'b001 << ei[i]) || gv3 !== 1'b1) begin
        bad++;
        $display("FAIL n3_rotation[%0d] got idx=%0d grant=%b required %0d", i, gi3, grant3, ei[i]);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    tick(1, 0, 4'h0, 3'h0, 0);
    tick(0, 0, 4'b0001, 3'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 4'b0011, 3'h0, 1);
      total++;
      if (grant4 !== 4'b0001 || gi4 !== 2'd0 || po4 !== 8'h39) begin
        bad++;
        $display("FAIL lock_hold[%0d] got grant=%b idx=%0d order=%h required 0001/0/39",
                 i, grant4, gi4, po4);
      end
    end
    tick(0, 0, 4'b0011, 3'h0, 0);
    total++;
    if (grant4 !== 4'b0010 || gi4 !== 2'd1) begin
      bad++;
      $display("FAIL lock_release got grant=%b idx=%0d required 0010/1", grant4, gi4);
    end
  endtask
`endif

  task automatic test_random();
    logic       r;
    logic       h;
    logic [3:0] q4;
    logic [2:0] q3;
    logic       lk;
    logic [3:0] eg4;
    logic [2:0] eg3;
    logic [7:0] ep4;
    logic [5:0] ep3;
    tick(1, 0, 4'h0, 3'h0, 0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      h  = ($urandom_range(0, 7) == 0);
      q4 = 4'($urandom);
      q3 = 3'($urandom);
      lk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) q4 = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) q3 = 3'b001 << $urandom_range(0, 2);
      tick(r, h, q4, q3, lk);
      eg4 = m_valid[0] ? 4'(1 << m_idx[0]) : 4'b0;
      eg3 = m_valid[1] ? 3'(1 << m_idx[1]) : 3'b0;
      for (int s = 0; s < 4; s++) ep4[s*2 +: 2] = 2'(m_ord[0][s]);
      for (int s = 0; s < 3; s++) ep3[s*2 +: 2] = 2'(m_ord[1][s]);
      total++;
      if (grant4 !== eg4 || gv4 !== m_valid[0] || gi4 !== 2'(m_idx[0]) || po4 !== ep4) begin
        bad++;
        $display("FAIL rand4[%0d] got grant=%b valid=%b idx=%0d order=%h required %b/%b/%0d/%h",
                 i, grant4, gv4, gi4, po4, eg4, m_valid[0], m_idx[0], ep4);
      end
      total++;
      if (grant3 !== eg3 || gv3 !== m_valid[1] || gi3 !== 2'(m_idx[1]) || po3 !== ep3) begin
        bad++;
        $display("FAIL rand3[%0d] got grant=%b valid=%b idx=%0d order=%h required %b/%b/%0d/%h",
                 i, grant3, gv3, gi3, po3, eg3, m_valid[1], m_idx[1], ep3);
      end
    end
  endtask

  initial begin
    test_reset_rotation();
    test_single_and_pair();
    test_halt();
    test_reset_midop();
    test_three_ports();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lru_priority_arbiter.md
Name: lru_priority_arbiter

Overview:
Parametrised N-port arbiter for the multi-ported memory front end, replacing the fixed 3-port priority encoding.
- Keeps a full priority order (a permutation of the port indices) in registers.
- Each cycle it issues a registered one-hot grant to the highest-ranked requesting port.
- It then demotes the granted port to lowest rank (least-recently-granted fairness).
- Sits between the port request logic and the memory bank mux; supports a global halt and an optional grant lock.

Parameters:
NUM_PORTS, 4, number of requesting ports (legal range 2..16, need not be a power of two)
IDX_W, $clog2(NUM_PORTS) (minimum 1), width of one port index; derived, not to be overridden

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous reset, active-high
halt  input  1  when 1, all state and outputs hold
req  input  NUM_PORTS  request vector, bit i = port i requests
grant  output  NUM_PORTS  registered one-hot grant, all zeros when nothing is granted
grant_valid  output  1  registered, 1 when grant is non-zero
grant_idx  output  IDX_W  registered index of the granted port, 0 when grant_valid=0
priority_order  output  NUM_PORTS*IDX_W  registered rank list; slot r is bits [r*IDX_W +: IDX_W]; slot 0 is highest priority
lock  input  1  present only with ARB_LOCK_EN, see Optional Feature

Behaviour:
- Reset (reset=1 at a rising edge, overrides halt):
  - priority_order slot r = r, i.e. order [0,1,..,N-1].
  - grant = 0, grant_valid = 0, grant_idx = 0.
  - Reset asserted mid-operation discards any pending order update.
- Latency: req sampled at edge t drives grant/grant_valid/grant_idx after edge t. One-cycle latency, no combinational req->grant path.
- Arbitration (halt=0, reset=0):
  - winner = the port in the lowest-numbered slot r whose req bit is 1.
  - grant <= onehot(winner), grant_idx <= winner, grant_valid <= 1.
- Order update on a grant:
  - The winner is removed from its slot r.
  - Slots r+1..N-1 each shift up one slot.
  - The winner is placed in slot N-1.
  - Slots 0..r-1 are unchanged.
- No request (req=0): grant <= 0, grant_valid <= 0, grant_idx <= 0; priority_order holds.
- halt=1: priority_order, grant, grant_valid and grant_idx all hold their current values; req is ignored.
- Invariant: priority_order is always a permutation of 0..N-1. A bench assertion checks this every cycle.
- Single requester: always granted the next cycle regardless of its rank.
- All requesting continuously: grants rotate strictly through the current order; every port is granted within N cycles (no starvation).
- Non-power-of-two N: index values >= N never appear in any slot or on grant_idx.
- Implementation: state is the rank register array only. Winner selection and the shift are combinational next-state logic. No other FSM state.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - The lock input exists.
  - If lock=1, grant_valid=1 and req[grant_idx]=1 at an edge (halt=0): grant and grant_idx repeat and priority_order holds, i.e. the current holder keeps the memory for a burst.
  - Once lock=0 or the holder drops req: normal arbitration resumes that same edge.
  - lock is ignored when grant_valid=0.
- Not defined: no lock port; every grant performs the normal order update.

Test Plan:
1. Reset with N=4, then req=4'b1111 held 5 cycles -> grants 0001,0010,0100,1000,0001 with grant_idx 0,1,2,3,0; after the first grant priority_order=[1,2,3,0].
2. From reset, req=4'b0100 for one cycle -> grant=0100, grant_idx=2, order=[0,1,3,2]. Then req=4'b0101 -> grant=0001, order=[1,3,2,0].
3. From reset, halt=1 with req=4'b1111 for 3 cycles -> grant=0, grant_valid=0, order=[0,1,2,3]. Release halt -> grant=0001 next cycle.
4. Reach order [1,2,3,0] with grant=0001, then reset=1 for one cycle with req=4'b1111 -> grant=0, grant_valid=0, order=[0,1,2,3]. With reset=0 the next cycle -> grant=0001.
5. NUM_PORTS=3, req=3'b111 for 6 cycles -> grant_idx 0,1,2,0,1,2; grant_idx never 3; permutation assertion holds.
6. With ARB_LOCK_EN: grant port 0, then req=4'b0011, lock=1 for 3 cycles -> grant=0001 each cycle, order unchanged. Then lock=0 -> grant=0010.
